layer0_input_quantizer: RTL and testbench

LAYER0_INPUT_QUANTIZER -- requirements
Module: layer0_input_quantizer

---
 rtl/logicnet_pkg.sv | 14 +
 rtl/feat_quant.sv | 30 +++
 rtl/layer0_input_quantizer.sv | 130 +++++++++++++
 tb/tb_layer0_input_quantizer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/logicnet_pkg.sv
// rtl/logicnet_pkg.sv - shared quantizer constants and fill/hold state type
package logicnet_pkg;

  localparam int Q_W_C    = 2;
  localparam int THR0_DEF = 64;
  localparam int THR1_DEF = 128;
  localparam int THR2_DEF = 192;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } fill_state_t;

endpackage

// File: rtl/feat_quant.sv
// rtl/feat_quant.sv - combinational 2-bit threshold quantizer for one raw feature
module feat_quant
  import logicnet_pkg::*;
#(
  parameter int FEAT_W = 8,
  parameter int Q_W    = Q_W_C,
  parameter int THR0   = THR0_DEF,
  parameter int THR1   = THR1_DEF,
  parameter int THR2   = THR2_DEF
) (
  input  logic [FEAT_W-1:0] x,
  output logic [Q_W-1:0]    code
);

  // One extra bit keeps a threshold of 2**FEAT_W representable (never reached).
  localparam logic [FEAT_W:0] T0 = (FEAT_W+1)'(THR0);
  localparam logic [FEAT_W:0] T1 = (FEAT_W+1)'(THR1);
  localparam logic [FEAT_W:0] T2 = (FEAT_W+1)'(THR2);

  logic [FEAT_W:0] xe;
  assign xe = {1'b0, x};

  always_comb begin
    code = Q_W'(0);
    if (xe >= T2)      code = Q_W'(3);
    else if (xe >= T1) code = Q_W'(2);
    else if (xe >= T0) code = Q_W'(1);
  end

endmodule

// File: rtl/layer0_input_quantizer.sv
// rtl/layer0_input_quantizer.sv - streams raw features into packed 2-bit samples for layer 0
// Optional framing checks on in_last are enabled by defining LAYER0_INPUT_FRAME_CHECK_EN.
module layer0_input_quantizer
  import logicnet_pkg::*;
#(
  parameter int N_FEAT = 32,
  parameter int FEAT_W = 8,
  parameter int Q_W    = Q_W_C,
  parameter int THR0   = THR0_DEF,
  parameter int THR1   = THR1_DEF,
  parameter int THR2   = THR2_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [FEAT_W-1:0]       in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_last,
  output logic [N_FEAT*Q_W-1:0]   out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    frame_err
);

  localparam int CNT_W = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_FEAT - 1);

  fill_state_t              state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [N_FEAT*Q_W-1:0]    asm_q, asm_d, asm_fill;
  logic [N_FEAT*Q_W-1:0]    out_data_q, out_data_d;
  logic                     out_valid_q, out_valid_d;
  logic                     ferr_q, ferr_d;
  logic                     rdy_q;
  logic [Q_W-1:0]           code;
  logic                     accept, last_idx, ferr, done_beat, xfer;

  feat_quant #(
    .FEAT_W (FEAT_W),
    .Q_W    (Q_W),
    .THR0   (THR0),
    .THR1   (THR1),
    .THR2   (THR2)
  ) u_quant (
    .x    (in_data),
    .code (code)
  );

  // rdy_q keeps in_ready low through reset and for the cycle of release.
  assign in_ready = rdy_q && (state_q == FILL);
  assign accept   = in_valid && in_ready;
  assign last_idx = (cnt_q == LAST_IDX);

`ifdef LAYER0_INPUT_FRAME_CHECK_EN
  assign ferr = accept && (in_last != last_idx);
`else
  logic unused_last;
  assign unused_last = in_last;
  assign ferr = 1'b0;
`endif

  assign done_beat = accept && last_idx && !ferr;
  assign xfer = ((state_q == HOLD) || done_beat) && (!out_valid_q || out_ready);

  always_comb begin
    asm_fill = asm_q;
    asm_fill[int'(cnt_q)*Q_W +: Q_W] = code;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    asm_d       = asm_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    ferr_d      = ferr_q || ferr;

    case (state_q)
      FILL: begin
        if (accept) begin
          if (ferr) begin
            asm_d = '0;
            cnt_d = '0;
          end else begin
            asm_d = asm_fill;
            cnt_d = last_idx ? '0 : cnt_q + 1'b1;
            if (done_beat && !xfer) state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (xfer) state_d = FILL;
      end
      default: state_d = FILL;
    endcase

    // A completing beat transfers its freshly written assembly, bypassing asm_q.
    if (xfer) begin
      out_data_d  = (state_q == HOLD) ? asm_q : asm_fill;
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FILL;
      cnt_q       <= '0;
      asm_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      ferr_q      <= 1'b0;
      rdy_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      asm_q       <= asm_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      ferr_q      <= ferr_d;
      rdy_q       <= 1'b1;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign frame_err = ferr_q;

endmodule

// File: tb/tb_layer0_input_quantizer.sv
// tb/tb_layer0_input_quantizer.sv - randomized scoreboard bench for layer0_input_quantizer
module tb_layer0_input_quantizer;

  localparam int NF = 8;
  localparam int FW = 8;
  localparam int QW = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [FW-1:0]     in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              in_last = 1'b0;
  logic [NF*QW-1:0]  out_data;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic              frame_err;

  always #5 clk = ~clk;

  layer0_input_quantizer #(.N_FEAT(NF), .FEAT_W(FW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_last   (in_last),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .frame_err (frame_err)
  );

  int          total = 0;
  int          bad = 0;
  logic [63:0] expq[$];
  int          cur[NF];
  int          feats[NF];
  int          kpos = 0;
  bit          ferr_exp = 0;
  bit          rand_rdy = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  function automatic int qref(input int x);
    if (x >= 192) return 3;
    if (x >= 128) return 2;
    if (x >= 64)  return 1;
    return 0;
  endfunction

  function automatic logic [63:0] pack_cur();
    logic [63:0] v = 0;
    for (int i = 0; i < NF; i++) v = v + (64'(cur[i]) << (QW * i));
    return v;
  endfunction

  task automatic model_beat(input int d);
`ifdef LAYER0_INPUT_FRAME_CHECK_EN
    if (in_last != (kpos == NF - 1)) begin
      ferr_exp = 1;
      kpos = 0;
      return;
    end
`endif
    cur[kpos] = qref(d);
    kpos++;
    if (kpos == NF) begin
      expq.push_back(pack_cur());
      kpos = 0;
    end
  endtask

  task automatic send_beat(input int d, input bit last);
    bit acc = 0;
    in_valid = 1'b1;
    in_data  = d[FW-1:0];
    in_last  = last;
    for (int t = 0; t < 200 && !acc; t++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        acc = 1;
      end
    end
    if (!acc) check_eq("beat_timeout", 0, 1);
    else model_beat(d);
  endtask

  task automatic send_sample();
    for (int k = 0; k < NF; k++) send_beat(feats[k], k == NF - 1);
    in_valid = 1'b0;
  endtask

  task automatic rand_feats();
    for (int k = 0; k < NF; k++) feats[k] = int'($urandom_range(0, 255));
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int t = 0; t < 100 && expq.size() > 0; t++) @(posedge clk);
    #1;
    check_eq("drain_empty", 64'(expq.size()), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    #2;
    check_eq("rst_out_valid", 64'(out_valid), 0);
    check_eq("rst_out_data", 64'(out_data), 0);
    check_eq("rst_frame_err", 64'(frame_err), 0);
    check_eq("rst_in_ready", 64'(in_ready), 0);
    expq.delete();
    kpos = 0;
    ferr_exp = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_eq("release_in_ready", 64'(in_ready), 0);
    @(posedge clk);
    #1;
    check_eq("first_clk_in_ready", 64'(in_ready), 1);
  endtask

  // Scoreboard: whatever out_valid presents must be the oldest expected sample.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (expq.size() == 0) check_eq("spurious_valid", 1, 0);
      else begin
        check_eq("out_data", 64'(out_data), expq[0]);
        if (out_ready) void'(expq.pop_front());
      end
    end
  end

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      out_ready = ($urandom_range(0, 2) != 0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    do_reset();

    // threshold edges and one-cycle latency
    out_ready = 1'b1;
    feats = '{63, 64, 127, 128, 191, 192, 0, 255};
    for (int k = 0; k < NF; k++) send_beat(feats[k], k == NF - 1);
    in_valid = 1'b0;
    check_eq("latency_valid", 64'(out_valid), 1);
    check_eq("thr_edges", 64'(out_data), 64'hCE94);
    drain();

    // backpressure: two samples queue up, second one parks in HOLD
    out_ready = 1'b0;
    rand_feats();
    send_sample();
    rand_feats();
    send_sample();
    check_eq("hold_in_ready", 64'(in_ready), 0);
    check_eq("hold_out_valid", 64'(out_valid), 1);
    repeat (3) @(posedge clk);
    #1;
    check_eq("hold_still_two", 64'(expq.size()), 2);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_eq("pulse1_left", 64'(expq.size()), 1);
    check_eq("pulse1_refill", 64'(in_ready), 1);
    repeat (2) @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_eq("pulse2_left", 64'(expq.size()), 0);
    check_eq("pulse2_valid", 64'(out_valid), 0);

    // drain coincides with completion of the next sample
    rand_feats();
    send_sample();
    rand_feats();
    for (int k = 0; k < NF - 1; k++) send_beat(feats[k], 1'b0);
    out_ready = 1'b1;
    send_beat(feats[NF-1], 1'b1);
    in_valid = 1'b0;
    check_eq("same_cycle_no_hold", 64'(in_ready), 1);
    check_eq("same_cycle_valid", 64'(out_valid), 1);
    check_eq("same_cycle_left", 64'(expq.size()), 1);
    drain();

    // reset mid-sample
    rand_feats();
    for (int k = 0; k < 5; k++) send_beat(feats[k], 1'b0);
    do_reset();
    check_eq("after_rst_valid", 64'(out_valid), 0);
    out_ready = 1'b1;
    rand_feats();
    send_sample();
    drain();

    // randomized traffic with random backpressure and idle gaps
    rand_rdy = 1;
    for (int s = 0; s < 20; s++) begin
      rand_feats();
      send_sample();
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    rand_rdy = 0;
    @(posedge clk);
    #2;
    drain();

    // framing: in_last on beat 3
    out_ready = 1'b1;
    rand_feats();
    for (int k = 0; k < 4; k++) send_beat(feats[k], k == 3);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
`ifdef LAYER0_INPUT_FRAME_CHECK_EN
    check_eq("frame_err_set", 64'(frame_err), 1);
`else
    check_eq("frame_err_tied", 64'(frame_err), 0);
`endif
    check_eq("frame_model", 64'(frame_err), 64'(ferr_exp));
    check_eq("frame_no_valid", 64'(out_valid), 0);
    rand_feats();
    send_sample();
    drain();
    check_eq("frame_err_final", 64'(frame_err), 64'(ferr_exp));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
